// File: rtl/ifetch_queue_pkg.sv
// Shared CPU definitions: fetch FSM encodings, the NOP constant and the
// layout of one fetched instruction as stored in the fetch queue.
package ifetch_queue_pkg;

  localparam logic [1:0] STATE_BOOT = 2'd0;
  localparam logic [1:0] STATE_RUN  = 2'd1;
  localparam logic [1:0] STATE_HALT = 2'd2;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetchEntry_t;

  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue_sync_fifo.sv
// Small synchronous FIFO with flush and occupancy count; the head entry is
// readable combinationally so a write is visible one cycle after the push.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_n,
  input  logic                     i_Push,
  input  logic [WIDTH-1:0]         i_Data,
  input  logic                     i_Pop,
  output logic [WIDTH-1:0]         o_Data,
  input  logic                     i_Flush,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic [$clog2(DEPTH):0]   o_Count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtrReg;
  logic [AW-1:0]    rdPtrReg;
  logic [AW:0]      countReg;
  logic             doPush;
  logic             doPop;

  assign o_Empty = (countReg == '0);
  assign o_Full  = (countReg == (AW+1)'(DEPTH));
  assign o_Count = countReg;
  assign o_Data  = mem[rdPtrReg];

  // A push into a full FIFO is allowed when the head leaves in the same cycle.
  assign doPop  = i_Pop & ~o_Empty & ~i_Flush;
  assign doPush = i_Push & (~o_Full | doPop) & ~i_Flush;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else if (i_Flush) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
      countReg <= '0;
    end else begin
      if (doPush) wrPtrReg <= wrPtrReg + AW'(1);
      if (doPop)  rdPtrReg <= rdPtrReg + AW'(1);
      countReg <= countReg + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (doPush) mem[wrPtrReg] <= i_Data;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: credit-limited bus requests, an in-order PC tag
// queue for in-flight requests, and a decode-facing instruction queue.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  output logic [29:0] o_IBusAddr,
  output logic        o_IBusReq,
  input  logic        i_IBusGnt,
  input  logic        i_IBusRdValid,
  input  logic [31:0] i_IBusRd,
  output logic        o_Valid,
  output logic [31:0] o_Inst,
  output logic [31:0] o_Pc,
  input  logic        i_Ready,
  input  logic        i_Redirect,
  input  logic [31:0] i_RedirectPc,
  input  logic        i_Halt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    stateReg;
  logic [1:0]    stateNext;
  logic [31:0]   fetchPcReg;
  logic [CW-1:0] dropCntReg;
  logic [CW-1:0] entries;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstandingNext;
  logic [CW:0]   used;
  logic          issue;
  logic          rspLegal;
  logic          rspDrop;
  logic          rspAccept;
  logic          headPop;
  logic          tagEmpty;
  logic          tagFull;
  logic          dataEmpty;
  logic          dataFull;
  logic [31:0]   tagPc;
  fetchEntry_t   headEntry;
  fetchEntry_t   pushEntry;

  // Queue slots plus in-flight requests never exceed DEPTH, so a response
  // always has somewhere to land.
  assign used      = {1'b0, entries} + {1'b0, outstanding};
  assign o_IBusReq = (stateReg == STATE_RUN) && !i_Redirect && (used < (CW+1)'(DEPTH));
  assign o_IBusAddr = fetchPcReg[31:2];
  assign issue     = o_IBusReq & i_IBusGnt;

  assign rspLegal  = i_IBusRdValid & ~tagEmpty;
  assign rspDrop   = rspLegal & (i_Redirect | (dropCntReg != '0));
  assign rspAccept = rspLegal & ~rspDrop;
  assign headPop   = o_Valid & i_Ready & ~i_Redirect;

  assign outstandingNext = outstanding + CW'(issue) - CW'(rspLegal);

  assign pushEntry.pc   = tagPc;
  assign pushEntry.inst = i_IBusRd;

  assign o_Valid = ~dataEmpty;
  assign o_Inst  = o_Valid ? headEntry.inst : '0;
  assign o_Pc    = o_Valid ? headEntry.pc   : '0;

  // Every response retires one tag, including ones being discarded.
  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) tagFifo (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Push  (issue),
    .i_Data  (fetchPcReg),
    .i_Pop   (rspLegal),
    .o_Data  (tagPc),
    .i_Flush (1'b0),
    .o_Full  (tagFull),
    .o_Empty (tagEmpty),
    .o_Count (outstanding)
  );

  sync_fifo #(.WIDTH($bits(fetchEntry_t)), .DEPTH(DEPTH)) instFifo (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Push  (rspAccept),
    .i_Data  (pushEntry),
    .i_Pop   (headPop),
    .o_Data  (headEntry),
    .i_Flush (i_Redirect),
    .o_Full  (dataFull),
    .o_Empty (dataEmpty),
    .o_Count (entries)
  );

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      STATE_BOOT: stateNext = STATE_RUN;
      STATE_RUN:  if (i_Halt) stateNext = STATE_HALT;
      STATE_HALT: if (!i_Halt) stateNext = STATE_RUN;
      default:    stateNext = STATE_BOOT;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      stateReg   <= STATE_BOOT;
      fetchPcReg <= RESET_PC;
      dropCntReg <= '0;
    end else begin
      stateReg <= stateNext;
      if (i_Redirect) begin
        fetchPcReg <= alignPc(i_RedirectPc);
      end else if (issue) begin
        fetchPcReg <= fetchPcReg + 32'd4;
      end
      // Everything still in flight after a redirect belongs to the old path.
      if (i_Redirect) begin
        dropCntReg <= outstandingNext;
      end else if (rspDrop) begin
        dropCntReg <= dropCntReg - CW'(1);
      end
    end
  end

  assert property (@(posedge i_Clk) disable iff (!i_Rst_n)
    !(i_IBusRdValid && tagEmpty));

  assert property (@(posedge i_Clk) disable iff (!i_Rst_n)
    !(issue && tagFull));

  assert property (@(posedge i_Clk) disable iff (!i_Rst_n)
    !(rspAccept && dataFull && !headPop));

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: random bus/decode traffic against a queue-based
// model of the fetch rules, plus directed redirect, halt, wrap and reset cases.
module tb_ifetch_queue;

  localparam int DEPTH  = 4;
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, gnt, rdValid, ready, redirect, halt;
  logic [31:0] rd, redirectPc;
  logic        req, valid;
  logic [29:0] addr;
  logic [31:0] inst, pc;

  logic        rst2_n, gnt2, rdValid2;
  logic [31:0] rd2;
  logic        req2, valid2;
  logic [29:0] addr2;
  logic [31:0] inst2, pc2;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .o_IBusAddr(addr), .o_IBusReq(req),
    .i_IBusGnt(gnt), .i_IBusRdValid(rdValid), .i_IBusRd(rd),
    .o_Valid(valid), .o_Inst(inst), .o_Pc(pc), .i_Ready(ready),
    .i_Redirect(redirect), .i_RedirectPc(redirectPc), .i_Halt(halt)
  );

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dutWrap (
    .i_Clk(clk), .i_Rst_n(rst2_n), .o_IBusAddr(addr2), .o_IBusReq(req2),
    .i_IBusGnt(gnt2), .i_IBusRdValid(rdValid2), .i_IBusRd(rd2),
    .o_Valid(valid2), .o_Inst(inst2), .o_Pc(pc2), .i_Ready(1'b1),
    .i_Redirect(1'b0), .i_RedirectPc(32'h0), .i_Halt(1'b0)
  );

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;
  int sLatMax = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } slvReq_t;

  // Reference model state
  int          mState;
  logic [31:0] mPc;
  logic [31:0] mQPc[$];
  logic [31:0] mQInst[$];
  logic [31:0] mFlight[$];
  int          mDrop;
  slvReq_t     sQ[$];

  bit          curGnt, curRv, curRdy, curRedir, curHalt;
  logic [31:0] curRpc, curRd;
  bit          mReq, mValid;
  logic [29:0] mAddr;
  logic [31:0] mHeadPc, mHeadInst;

  function automatic logic [31:0] instFn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic modelReset(input logic [31:0] rp);
    mState = M_BOOT;
    mPc    = rp;
    mQPc.delete();
    mQInst.delete();
    mFlight.delete();
    mDrop  = 0;
    sQ.delete();
  endtask

  // Apply one cycle of inputs at the falling edge and predict the outputs.
  task automatic drive(input bit g, input bit rvEn, input bit rdy, input bit redir,
                       input logic [31:0] rpc, input bit hlt);
    @(negedge clk);
    curGnt = g; curRdy = rdy; curRedir = redir; curRpc = rpc; curHalt = hlt;
    curRv  = rvEn && (sQ.size() > 0) && (sQ[0].due <= cyc);
    curRd  = curRv ? instFn(sQ[0].addr) : $urandom;
    gnt = g; rdValid = curRv; rd = curRd; ready = rdy;
    redirect = redir; redirectPc = rpc; halt = hlt;
    mReq      = (mState == M_RUN) && !redir && ((mQPc.size() + mFlight.size()) < DEPTH);
    mAddr     = mPc[31:2];
    mValid    = mQPc.size() > 0;
    mHeadPc   = mValid ? mQPc[0] : 32'h0;
    mHeadInst = mValid ? mQInst[0] : 32'h0;
    #1;
  endtask

  // Advance the model across the rising edge using the inputs of drive().
  task automatic commit();
    bit          popNow;
    logic [31:0] tag;
    slvReq_t     s;
    @(posedge clk);
    popNow = (mQPc.size() > 0) && curRdy && !curRedir;
    if (popNow) begin
      void'(mQPc.pop_front());
      void'(mQInst.pop_front());
    end
    if (curRv && mFlight.size() > 0) begin
      tag = mFlight.pop_front();
      void'(sQ.pop_front());
      if (!curRedir) begin
        if (mDrop > 0) mDrop--;
        else begin
          mQPc.push_back(tag);
          mQInst.push_back(curRd);
        end
      end
    end
    if (mReq && curGnt) begin
      mFlight.push_back(mPc);
      s.addr = mPc;
      s.due  = cyc + 1 + int'($urandom_range(0, sLatMax));
      sQ.push_back(s);
      mPc = mPc + 32'd4;
    end
    if (curRedir) begin
      mQPc.delete();
      mQInst.delete();
      mPc   = {curRpc[31:2], 2'b00};
      mDrop = mFlight.size();
    end
    case (mState)
      M_BOOT:  mState = M_RUN;
      M_RUN:   if (curHalt) mState = M_HALT;
      default: if (!curHalt) mState = M_RUN;
    endcase
    cyc++;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    gnt = 0; rdValid = 0; ready = 0; redirect = 0; halt = 0; rd = 0; redirectPc = 0;
    modelReset(32'h0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; rst2_n = 1'b1;
    #1;
    rst_n = 1'b0; rst2_n = 1'b0;
    modelReset(32'h0);
    #1;
    nChecks++;
    if (valid !== 1'b0 || req !== 1'b0) begin
      nFails++;
      $display("FAIL reset_ctrl: valid=%b req=%b, required 0 0", valid, req);
    end
    nChecks++;
    if (addr !== 30'h0 || inst !== 32'h0 || pc !== 32'h0) begin
      nFails++;
      $display("FAIL reset_data: addr=%h inst=%h pc=%h, required 0 0 0", addr, inst, pc);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1, 1, 1, 0, 32'h0, 0);
    nChecks++;
    if (req !== 1'b0) begin
      nFails++;
      $display("FAIL boot_no_req: req=%b, required 0", req);
    end
    commit();
    drive(1, 1, 1, 0, 32'h0, 0);
    nChecks++;
    if (req !== 1'b1 || addr !== 30'h0) begin
      nFails++;
      $display("FAIL first_req: req=%b addr=%h, required 1 0", req, addr);
    end
    commit();
    $display("test_reset done");
  endtask

  task automatic test_stream();
    logic [31:0] expPc;
    int          nValid;
    doReset();
    sLatMax = 0; expPc = 32'h0; nValid = 0;
    for (int i = 0; i < 24; i++) begin
      drive(1, 1, 1, 0, 32'h0, 0);
      nChecks++;
      if (req !== mReq || addr !== mAddr || valid !== mValid ||
          (mValid && (pc !== mHeadPc || inst !== mHeadInst))) begin
        nFails++;
        $display("FAIL stream_model cyc=%0d: req=%b addr=%h valid=%b pc=%h inst=%h, required %b %h %b %h %h",
                 i, req, addr, valid, pc, inst, mReq, mAddr, mValid, mHeadPc, mHeadInst);
      end
      if (valid) begin
        nChecks++;
        if (pc !== expPc) begin
          nFails++;
          $display("FAIL stream_pc: pc=%h, required %h", pc, expPc);
        end
        $display("stream pop pc=%h inst=%h", pc, inst);
        expPc = expPc + 32'd4;
        nValid++;
      end
      commit();
    end
    nChecks++;
    if (nValid != 21) begin
      nFails++;
      $display("FAIL stream_count: valid cycles=%0d, required 21", nValid);
    end
  endtask

  task automatic test_backpressure();
    int grants;
    bit lastReq, resumed;
    doReset();
    sLatMax = 0; grants = 0; lastReq = 1'b1; resumed = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(1, 1, 0, 0, 32'h0, 0);
      if (req && gnt) grants++;
      lastReq = req;
      commit();
    end
    nChecks++;
    if (grants != DEPTH || lastReq !== 1'b0) begin
      nFails++;
      $display("FAIL backpressure_grants: grants=%0d req=%b, required %0d 0", grants, lastReq, DEPTH);
    end
    drive(1, 1, 1, 0, 32'h0, 0);
    nChecks++;
    if (valid !== 1'b1 || pc !== 32'h0) begin
      nFails++;
      $display("FAIL backpressure_head: valid=%b pc=%h, required 1 00000000", valid, pc);
    end
    commit();
    for (int i = 0; i < 4 && !resumed; i++) begin
      drive(1, 1, 1, 0, 32'h0, 0);
      if (req === 1'b1) resumed = 1'b1;
      commit();
    end
    nChecks++;
    if (!resumed) begin
      nFails++;
      $display("FAIL backpressure_resume: req stayed 0, required 1 within 4 cycles");
    end
    $display("test_backpressure grants=%0d", grants);
  endtask

  task automatic test_redirect();
    int rsp;
    bit found;
    doReset();
    sLatMax = 0; rsp = 0; found = 1'b0;
    repeat (4) begin
      drive(1, 0, 1, 0, 32'h0, 0);
      commit();
    end
    drive(1, 0, 1, 1, 32'h100, 0);
    nChecks++;
    if (req !== 1'b0) begin
      nFails++;
      $display("FAIL redirect_req: req=%b, required 0", req);
    end
    commit();
    for (int i = 0; i < 20 && !found; i++) begin
      drive(1, 1, 1, 0, 32'h0, 0);
      if (i == 0) begin
        nChecks++;
        if (dut.dropCntReg !== 3'd3) begin
          nFails++;
          $display("FAIL redirect_drop: dropCnt=%0d, required 3", dut.dropCntReg);
        end
      end
      if (valid) begin
        found = 1'b1;
        nChecks++;
        if (pc !== 32'h100 || rsp != 4) begin
          nFails++;
          $display("FAIL redirect_first: pc=%h responses=%0d, required 00000100 4", pc, rsp);
        end
      end else if (rdValid) rsp++;
      commit();
    end
    nChecks++;
    if (!found) begin
      nFails++;
      $display("FAIL redirect_timeout: no o_Valid within 20 cycles, required one");
    end
    $display("test_redirect responses=%0d", rsp);
  endtask

  task automatic test_coincident();
    bit found;
    doReset();
    sLatMax = 0; found = 1'b0;
    repeat (4) begin
      drive(1, 0, 0, 0, 32'h0, 0);
      commit();
    end
    drive(1, 1, 0, 0, 32'h0, 0);
    commit();
    drive(1, 1, 1, 1, 32'h101, 0);
    nChecks++;
    if (valid !== 1'b1 || rdValid !== 1'b1) begin
      nFails++;
      $display("FAIL coincident_setup: valid=%b rdValid=%b, required 1 1", valid, rdValid);
    end
    commit();
    drive(1, 1, 1, 0, 32'h0, 0);
    nChecks++;
    if (valid !== 1'b0 || addr !== 30'h40 || dut.dropCntReg !== 3'd2) begin
      nFails++;
      $display("FAIL coincident_after: valid=%b addr=%h drop=%0d, required 0 00000040 2",
               valid, addr, dut.dropCntReg);
    end
    commit();
    for (int i = 0; i < 20 && !found; i++) begin
      drive(1, 1, 1, 0, 32'h0, 0);
      if (valid) begin
        found = 1'b1;
        nChecks++;
        if (pc !== 32'h100) begin
          nFails++;
          $display("FAIL coincident_first: pc=%h, required 00000100", pc);
        end
      end
      commit();
    end
    nChecks++;
    if (!found) begin
      nFails++;
      $display("FAIL coincident_timeout: no o_Valid within 20 cycles, required one");
    end
    $display("test_coincident done");
  endtask

  task automatic test_halt();
    logic [31:0] heldPc;
    doReset();
    sLatMax = 1; heldPc = 32'h0;
    repeat (6) begin
      drive(1, 1, 0, 0, 32'h0, 0);
      commit();
    end
    for (int i = 0; i < 12; i++) begin
      drive(1, 1, 1, 0, 32'h0, 1);
      nChecks++;
      if (req !== mReq || addr !== mAddr || valid !== mValid ||
          (mValid && (pc !== mHeadPc || inst !== mHeadInst))) begin
        nFails++;
        $display("FAIL halt_model cyc=%0d: req=%b addr=%h valid=%b pc=%h, required %b %h %b %h",
                 i, req, addr, valid, pc, mReq, mAddr, mValid, mHeadPc);
      end
      if (i > 0) begin
        nChecks++;
        if (req !== 1'b0) begin
          nFails++;
          $display("FAIL halt_req cyc=%0d: req=%b, required 0", i, req);
        end
      end
      commit();
      if (i == 0) heldPc = mPc;
    end
    drive(1, 1, 1, 0, 32'h0, 0);
    nChecks++;
    if (valid !== 1'b0 || req !== 1'b0) begin
      nFails++;
      $display("FAIL halt_drain: valid=%b req=%b, required 0 0", valid, req);
    end
    commit();
    drive(1, 1, 1, 0, 32'h0, 0);
    nChecks++;
    if (req !== 1'b1 || addr !== heldPc[31:2]) begin
      nFails++;
      $display("FAIL halt_resume: req=%b addr=%h, required 1 %h", req, addr, heldPc[31:2]);
    end
    commit();
    $display("test_halt held pc=%h", heldPc);
  endtask

  task automatic test_random();
    bit hb, redir;
    int errs;
    sLatMax = 3; hb = 1'b0; errs = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 4) hb = ~hb;
      redir = ($urandom_range(0, 99) < 5);
      drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 75,
            $urandom_range(0, 99) < 60, redir, $urandom, hb);
      nChecks++;
      if (req !== mReq || addr !== mAddr || valid !== mValid ||
          (mValid && (pc !== mHeadPc || inst !== mHeadInst))) begin
        nFails++; errs++;
        $display("FAIL random_model cyc=%0d: req=%b addr=%h valid=%b pc=%h inst=%h, required %b %h %b %h %h",
                 i, req, addr, valid, pc, inst, mReq, mAddr, mValid, mHeadPc, mHeadInst);
      end
      commit();
    end
    $display("test_random 400 cycles, %0d mismatching cycles", errs);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 12; i++) begin
      drive($urandom_range(0, 1), 1, 0, 0, 32'h0, 0);
      commit();
    end
    #2 rst_n = 1'b0;
    #1;
    nChecks++;
    if (valid !== 1'b0 || req !== 1'b0) begin
      nFails++;
      $display("FAIL async_reset: valid=%b req=%b, required 0 0", valid, req);
    end
    gnt = 0; rdValid = 0; ready = 0; redirect = 0; halt = 0;
    modelReset(32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1, 1, 1, 0, 32'h0, 0);
    nChecks++;
    if (req !== 1'b0) begin
      nFails++;
      $display("FAIL async_boot: req=%b, required 0", req);
    end
    commit();
    drive(1, 1, 1, 0, 32'h0, 0);
    nChecks++;
    if (req !== 1'b1 || addr !== 30'h0) begin
      nFails++;
      $display("FAIL async_refetch: req=%b addr=%h, required 1 0", req, addr);
    end
    commit();
    $display("test_async_reset done");
  endtask

  task automatic test_wrap();
    logic [31:0] got[$];
    bit          pend, nowIssue;
    logic [31:0] pendAddr, nowAddr;
    gnt2 = 1'b1; rdValid2 = 1'b0; pend = 1'b0; pendAddr = 32'h0;
    @(posedge clk);
    #2 rst2_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rdValid2 = pend;
      rd2 = instFn(pendAddr);
      #1;
      if (i == 0) begin
        nChecks++;
        if (req2 !== 1'b0 || addr2 !== 30'h3FFF_FFFE) begin
          nFails++;
          $display("FAIL wrap_boot: req=%b addr=%h, required 0 3ffffffe", req2, addr2);
        end
      end
      if (valid2) begin
        got.push_back(pc2);
        nChecks++;
        if (inst2 !== instFn(pc2)) begin
          nFails++;
          $display("FAIL wrap_inst: inst=%h, required %h", inst2, instFn(pc2));
        end
      end
      nowIssue = req2 & gnt2;
      nowAddr  = {addr2, 2'b00};
      @(posedge clk);
      pend = nowIssue;
      pendAddr = nowAddr;
    end
    nChecks++;
    if (got.size() < 3) begin
      nFails++;
      $display("FAIL wrap_count: entries=%0d, required at least 3", got.size());
    end else if (got[0] !== 32'hFFFF_FFF8 || got[1] !== 32'hFFFF_FFFC || got[2] !== 32'h0) begin
      nFails++;
      $display("FAIL wrap_seq: %h %h %h, required fffffff8 fffffffc 00000000", got[0], got[1], got[2]);
    end
    $display("test_wrap entries=%0d", got.size());
  endtask

  initial begin
    gnt = 0; rdValid = 0; ready = 0; redirect = 0; halt = 0; rd = 0; redirectPc = 0;
    gnt2 = 0; rdValid2 = 0; rd2 = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_coincident();
    test_halt();
    test_random();
    test_async_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, is the number of queue entries and the maximum requests in flight; it SHALL be a power of 2 and at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, is the first fetch byte address after reset.
REQ-003 i_Clk  in  1  is the single clock; all state SHALL change on its rising edge.
REQ-004 i_Rst_n  in  1  is the asynchronous, active-low reset.
REQ-005 o_IBusAddr  out  30  is the word address of the fetch request.
REQ-006 o_IBusReq  out  1  is the fetch request valid signal.
REQ-007 i_IBusGnt  in  1  means the request was accepted this cycle.
REQ-008 i_IBusRdValid  in  1  means read data is returned this cycle; responses arrive in order, at least 1 cycle after grant.
REQ-009 i_IBusRd  in  32  is the instruction word returned.
REQ-010 o_Valid  out  1  means the queue head holds an instruction.
REQ-011 o_Inst  out  32  is the head instruction.
REQ-012 o_Pc  out  32  is the head byte address.
REQ-013 i_Ready  in  1  means decode accepts the head this cycle.
REQ-014 i_Redirect  in  1  is a branch or jump redirect pulse.
REQ-015 i_RedirectPc  in  32  is the redirect target byte address; bits [1:0] are ignored.
REQ-016 i_Halt  in  1  stops new requests while held high; queued entries still drain.

Function
REQ-017 The FSM SHALL have three states: BOOT, RUN and HALT.
- BOOT: entered on reset; moves to RUN on the next cycle and issues no request.
- RUN: moves to HALT when i_Halt=1.
- HALT: moves back to RUN when i_Halt=0.
REQ-018 o_IBusReq SHALL be 1 only in RUN, with i_Redirect=0 and credits available, where credits = DEPTH - (entries + outstanding).
REQ-019 A request is issued when o_IBusReq & i_IBusGnt; on issue the fetch PC SHALL advance by 4 and outstanding SHALL increment.
- The fetch PC wraps modulo 2^32.
- While o_IBusReq=1 and i_IBusGnt=0, o_IBusAddr SHALL be held.
REQ-020 Each request SHALL record its PC in order, so o_Pc equals the address of the request that produced o_Inst.
REQ-021 An accepted response (i_IBusRdValid with drop count 0) SHALL be written at the tail.
- It becomes visible at o_Valid/o_Inst the next cycle, giving 1-cycle queue latency.
- Outstanding decrements when the response arrives.
REQ-022 A head pop (o_Valid & i_Ready) and a tail push in the same cycle SHALL both occur; this also applies when the queue is full.
REQ-023 By construction the queue cannot overflow, because credits cover outstanding requests.
- An i_IBusRdValid with outstanding=0 is a protocol error; the assertion SHALL fire and the data SHALL be ignored.
REQ-024 On i_Redirect, the next cycle SHALL show the following:
- the queue is empty and o_Valid=0;
- the fetch PC equals {i_RedirectPc[31:2],2'b00};
- the drop count is loaded with outstanding, including any request granted in the redirect cycle.
REQ-025 While the drop count is nonzero, each i_IBusRdValid SHALL decrement it and SHALL NOT be written.
- New requests MAY issue during this time, limited by credits (outstanding still counts the dropped requests).
REQ-026 A response arriving in the redirect cycle itself SHALL be dropped.
REQ-027 i_Redirect SHALL take priority over i_Ready, push and i_Halt in the same cycle.
- A redirect during HALT updates the fetch PC; the FSM stays in HALT.
REQ-028 o_Inst and o_Pc SHALL be don't-care while o_Valid=0.

Reset
REQ-029 Reset SHALL set the following: state=BOOT, fetch PC=RESET_PC, entries=0, outstanding=0, drop count=0, o_Valid=0, o_IBusReq=0, o_IBusAddr=RESET_PC[31:2], o_Inst=0, o_Pc=0.
REQ-030 Reset asserted mid-operation SHALL discard all entries and in-flight bookkeeping immediately; responses after reset deassertion to pre-reset requests are out of contract.

Structure
REQ-031 FSM state encodings and the NOP instruction constant 32'h0000_0013 SHALL reside in the shared CPU package.
REQ-032 Queue storage SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH; push, pop, flush, full, empty, count) that carries {pc, inst}.
- The PC-tag FIFO SHALL be a second instance of the same sub-module.

Verification
REQ-033 Reset then streaming fetch:
- Stimulus: release reset; i_IBusGnt=1; response latency 1; i_Ready=1.
- Required: o_Pc sequence 0x0,0x4,0x8,... with one o_Valid per cycle after the start-up latency.
REQ-034 Backpressure, DEPTH=4:
- Stimulus: i_Ready=0.
- Required: exactly 4 grants, then o_IBusReq=0.
- Then: on i_Ready=1, head o_Pc=0x0 and requests resume.
REQ-035 Redirect with 3 in flight:
- Stimulus: i_Redirect=1, i_RedirectPc=0x100.
- Required: the next 3 responses are dropped; the first o_Valid carries o_Pc=0x100.
REQ-036 Redirect coincident events:
- Stimulus: redirect in the same cycle as a response, a pop and a grant.
- Required: the response is dropped, the queue is empty, drop count=outstanding, and the next o_IBusAddr=0x40 for target 0x101.
REQ-037 Halt and wrap:
- Stimulus: i_Halt=1 in RUN.
- Required: no requests; queued entries drain; release resumes at the held PC.
- Stimulus: RESET_PC=0xFFFF_FFF8.
- Required: o_Pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
REQ-038 Async reset mid-burst:
- Stimulus: assert i_Rst_n=0 asynchronously between edges.
- Required: o_Valid=0 and o_IBusReq=0 immediately; after release, BOOT runs for one cycle and then RESET_PC is fetched.
